photo_sensor_conditioner: RTL and testbench

- Upstream conditioning stage for the photo-interrupter input, placed between the raw sensor pin and the LED/indicator stage.
- Synchronises the asynchronous sensor level and debounces it with a four-state FSM.
- Outputs a clean level, single-cycle rise/fall pulses, a saturating interruption counter and a stuck-beam flag.
- Downstream logic consumes sensor_clean in place of the raw pin.

---
 rtl/photo_sensor_conditioner.sv | 166 ++++++++++++++++
 tb/tb_photo_sensor_conditioner.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/photo_sensor_conditioner.sv
// Purpose : synchronise and debounce the photo-interrupter pin; emit clean level, edge pulses, interruption count, stuck flag.
// Latency : a held level change first sampled on edge 0 reaches sensor_clean / pulse on edge DEBOUNCE_CYCLES+2.
// Backpressure: none; free-running conditioner, outputs are levels/pulses with no handshake.
//
// Ports:
//   clk, rst (async, active-high)
//   sensor_raw    : raw asynchronous sensor level, 1 = beam interrupted
//   clear         : synchronous clear of event_count and the stuck detector
//   sensor_clean  : debounced level
//   rise_pulse    : one cycle high when sensor_clean goes 0->1
//   fall_pulse    : one cycle high when sensor_clean goes 1->0
//   event_count   : saturating count of accepted rising edges
//   blocked_stuck : sensor_clean has been high for STUCK_CYCLES cycles
module photo_sensor_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int CNT_WIDTH       = 16,
    parameter int STUCK_CYCLES    = 50000000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sensor_raw,
    input  logic                 clear,
    output logic                 sensor_clean,
    output logic                 rise_pulse,
    output logic                 fall_pulse,
    output logic [CNT_WIDTH-1:0] event_count,
    output logic                 blocked_stuck
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int ST_W = $clog2(STUCK_CYCLES + 1);

    localparam logic [DB_W-1:0]      DB_MAX  = DB_W'(DEBOUNCE_CYCLES);
    localparam logic [DB_W-1:0]      DB_ONE  = DB_W'(1);
    localparam logic [ST_W-1:0]      ST_MAX  = ST_W'(STUCK_CYCLES);
    localparam logic [ST_W-1:0]      ST_ONE  = ST_W'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE_LOW  = 2'd0,
        CHK_HIGH  = 2'd1,
        IDLE_HIGH = 2'd2,
        CHK_LOW   = 2'd3
    } state_t;

    logic            s1;
    logic            s2;
    state_t          state;
    state_t          state_nxt;
    logic [DB_W-1:0] db_cnt;
    logic [DB_W-1:0] db_cnt_nxt;
    logic            clean_nxt;
    logic            rise_nxt;
    logic            fall_nxt;
    logic [ST_W-1:0] stuck_cnt;

    // Two-flop synchroniser; only s2 is safe to use.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= sensor_raw;
            s2 <= s1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE_LOW;
            db_cnt       <= '0;
            sensor_clean <= 1'b0;
            rise_pulse   <= 1'b0;
            fall_pulse   <= 1'b0;
        end else begin
            state        <= state_nxt;
            db_cnt       <= db_cnt_nxt;
            sensor_clean <= clean_nxt;
            rise_pulse   <= rise_nxt;
            fall_pulse   <= fall_nxt;
        end
    end

    // A change is accepted once s2 has disagreed with the clean level on
    // the entry sample plus DEBOUNCE_CYCLES further samples.
    always_comb begin
        state_nxt  = state;
        db_cnt_nxt = db_cnt;
        clean_nxt  = sensor_clean;
        rise_nxt   = 1'b0;
        fall_nxt   = 1'b0;
        case (state)
            IDLE_LOW: begin
                if (s2) begin
                    state_nxt  = CHK_HIGH;
                    db_cnt_nxt = DB_ONE;
                end
            end
            CHK_HIGH: begin
                if (!s2) begin
                    state_nxt  = IDLE_LOW;
                    db_cnt_nxt = '0;
                end else if (db_cnt == DB_MAX) begin
                    state_nxt  = IDLE_HIGH;
                    db_cnt_nxt = '0;
                    clean_nxt  = 1'b1;
                    rise_nxt   = 1'b1;
                end else begin
                    db_cnt_nxt = db_cnt + DB_ONE;
                end
            end
            IDLE_HIGH: begin
                if (!s2) begin
                    state_nxt  = CHK_LOW;
                    db_cnt_nxt = DB_ONE;
                end
            end
            CHK_LOW: begin
                if (s2) begin
                    state_nxt  = IDLE_HIGH;
                    db_cnt_nxt = '0;
                end else if (db_cnt == DB_MAX) begin
                    state_nxt  = IDLE_LOW;
                    db_cnt_nxt = '0;
                    clean_nxt  = 1'b0;
                    fall_nxt   = 1'b1;
                end else begin
                    db_cnt_nxt = db_cnt + DB_ONE;
                end
            end
            default: begin
                state_nxt  = IDLE_LOW;
                db_cnt_nxt = '0;
            end
        endcase
    end

    // Counts the registered rise_pulse, so a clear seen while the pulse is
    // high wins and that edge is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            event_count <= '0;
        end else if (clear) begin
            event_count <= '0;
        end else if (rise_pulse && (event_count != CNT_MAX)) begin
            event_count <= event_count + CNT_ONE;
        end
    end

    // Stuck detector also drops on the accepting fall edge, so blocked_stuck
    // is never high while sensor_clean is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stuck_cnt     <= '0;
            blocked_stuck <= 1'b0;
        end else if (clear || !sensor_clean || fall_nxt) begin
            stuck_cnt     <= '0;
            blocked_stuck <= 1'b0;
        end else if (stuck_cnt != ST_MAX) begin
            stuck_cnt     <= stuck_cnt + ST_ONE;
            blocked_stuck <= (stuck_cnt == (ST_MAX - ST_ONE));
        end
    end

endmodule

// File: tb/tb_photo_sensor_conditioner.sv
// Purpose : exercise photo_sensor_conditioner with directed scenarios and randomised pin activity.
// Latency : outputs observed on the falling edge after each rising edge.
// Backpressure: none.
module tb_photo_sensor_conditioner;

    localparam int D  = 4;
    localparam int CW = 4;
    localparam int ST = 20;
    localparam int CNT_SAT = (1 << CW) - 1;

    logic          clk;
    logic          rst;
    logic          sensor_raw;
    logic          clear;
    logic          sensor_clean;
    logic          rise_pulse;
    logic          fall_pulse;
    logic [CW-1:0] event_count;
    logic          blocked_stuck;

    int checks = 0;
    int errors = 0;

    photo_sensor_conditioner #(
        .DEBOUNCE_CYCLES(D),
        .CNT_WIDTH      (CW),
        .STUCK_CYCLES   (ST)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .sensor_raw   (sensor_raw),
        .clear        (clear),
        .sensor_clean (sensor_clean),
        .rise_pulse   (rise_pulse),
        .fall_pulse   (fall_pulse),
        .event_count  (event_count),
        .blocked_stuck(blocked_stuck)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: the pin reaches the debouncer two edges late; the clean
    // level flips once D+1 consecutive delayed samples disagree with it.
    bit hist[$] = '{1'b0, 1'b0};
    int m_run     = 0;
    bit m_clean   = 1'b0;
    bit m_rise    = 1'b0;
    bit m_fall    = 1'b0;
    int m_count   = 0;
    int m_high    = 0;
    bit m_blocked = 1'b0;

    always @(posedge clk or posedge rst) begin
        bit s_v;
        bit prev_clean;
        bit prev_rise;
        if (rst) begin
            hist      = '{1'b0, 1'b0};
            m_run     = 0;
            m_clean   = 1'b0;
            m_rise    = 1'b0;
            m_fall    = 1'b0;
            m_count   = 0;
            m_high    = 0;
            m_blocked = 1'b0;
        end else begin
            s_v = hist.pop_front();
            hist.push_back(sensor_raw);
            prev_clean = m_clean;
            prev_rise  = m_rise;
            m_rise = 1'b0;
            m_fall = 1'b0;
            m_run  = (s_v != m_clean) ? m_run + 1 : 0;
            if (m_run == D + 1) begin
                m_clean = !m_clean;
                m_run   = 0;
                if (m_clean) m_rise = 1'b1;
                else         m_fall = 1'b1;
            end
            if (clear)                                m_count = 0;
            else if (prev_rise && m_count < CNT_SAT)  m_count = m_count + 1;
            if (clear || !prev_clean || m_fall)       m_high = 0;
            else if (m_high < ST)                     m_high = m_high + 1;
            m_blocked = (m_high == ST);
        end
    end

    function automatic logic [7:0] dut_v();
        return {sensor_clean, rise_pulse, fall_pulse, event_count, blocked_stuck};
    endfunction

    function automatic logic [7:0] model_v();
        logic [CW-1:0] c;
        c = CW'(m_count);
        return {m_clean, m_rise, m_fall, c, m_blocked};
    endfunction

    // Apply inputs at a falling edge and return at the next falling edge.
    task automatic drive(input logic r, input logic c);
        sensor_raw = r;
        clear      = c;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        sensor_raw = 1'b0;
        clear = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        sensor_raw = 1'b1;
        clear = 1'b0;
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (dut_v() !== 8'h00) begin
                errors++;
                $display("FAIL reset_outputs cyc %0d: got %h want 00", k, dut_v());
            end
        end
        do_reset();
    endtask

    task automatic test_clean_step();
        do_reset();
        for (int k = 0; k < 30; k++) begin
            drive(1'b1, 1'b0);
            checks++;
            if (rise_pulse !== (k == 6)) begin
                errors++;
                $display("FAIL step_rise edge %0d: got %b want %b", k, rise_pulse, (k == 6));
            end
            checks++;
            if (sensor_clean !== (k >= 6)) begin
                errors++;
                $display("FAIL step_clean edge %0d: got %b want %b", k, sensor_clean, (k >= 6));
            end
            checks++;
            if (blocked_stuck !== (k >= 26)) begin
                errors++;
                $display("FAIL step_stuck edge %0d: got %b want %b", k, blocked_stuck, (k >= 26));
            end
            checks++;
            if (dut_v() !== model_v()) begin
                errors++;
                $display("FAIL step_model edge %0d: dut %h model %h", k, dut_v(), model_v());
            end
        end
        for (int k = 0; k < 10; k++) begin
            drive(1'b0, 1'b0);
            checks++;
            if (fall_pulse !== (k == 6)) begin
                errors++;
                $display("FAIL step_fall edge %0d: got %b want %b", k, fall_pulse, (k == 6));
            end
            checks++;
            if (blocked_stuck !== (k < 6)) begin
                errors++;
                $display("FAIL step_unstuck edge %0d: got %b want %b", k, blocked_stuck, (k < 6));
            end
        end
        checks++;
        if (event_count !== CW'(1)) begin
            errors++;
            $display("FAIL step_count: got %0d want 1", event_count);
        end
    endtask

    task automatic test_glitch();
        do_reset();
        for (int g = 0; g < 5; g++) begin
            for (int k = 0; k < 7; k++) begin
                drive(k < 3, 1'b0);
                checks++;
                if ({sensor_clean, rise_pulse, fall_pulse} !== 3'b000) begin
                    errors++;
                    $display("FAIL glitch_out rep %0d cyc %0d: got %b want 000", g, k,
                             {sensor_clean, rise_pulse, fall_pulse});
                end
            end
        end
        checks++;
        if (event_count !== '0) begin
            errors++;
            $display("FAIL glitch_count: got %0d want 0", event_count);
        end
    endtask

    task automatic test_chatter();
        int nrise = 0;
        do_reset();
        for (int g = 0; g < 3; g++) begin
            drive(1'b1, 1'b0); nrise += int'(rise_pulse);
            drive(1'b1, 1'b0); nrise += int'(rise_pulse);
            drive(1'b0, 1'b0); nrise += int'(rise_pulse);
        end
        for (int k = 0; k < 12; k++) begin
            drive(1'b1, 1'b0);
            nrise += int'(rise_pulse);
            checks++;
            if (rise_pulse !== (k == 6)) begin
                errors++;
                $display("FAIL chatter_rise edge %0d: got %b want %b", k, rise_pulse, (k == 6));
            end
        end
        checks++;
        if (nrise != 1) begin
            errors++;
            $display("FAIL chatter_npulse: got %0d want 1", nrise);
        end
        checks++;
        if (event_count !== CW'(1)) begin
            errors++;
            $display("FAIL chatter_count: got %0d want 1", event_count);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 1; i <= 17; i++) begin
            repeat (8) drive(1'b1, 1'b0);
            repeat (8) drive(1'b0, 1'b0);
            checks++;
            if (event_count !== CW'((i < CNT_SAT) ? i : CNT_SAT)) begin
                errors++;
                $display("FAIL sat_count after %0d: got %0d want %0d", i, event_count,
                         (i < CNT_SAT) ? i : CNT_SAT);
            end
        end
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, k == 7);
            if (k == 6) begin
                checks++;
                if (rise_pulse !== 1'b1) begin
                    errors++;
                    $display("FAIL sat_18th_rise: got %b want 1", rise_pulse);
                end
            end
        end
        checks++;
        if (event_count !== '0) begin
            errors++;
            $display("FAIL sat_clear: got %0d want 0", event_count);
        end
        repeat (8) drive(1'b0, 1'b0);
        checks++;
        if (dut_v() !== model_v()) begin
            errors++;
            $display("FAIL sat_model: dut %h model %h", dut_v(), model_v());
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int k = 0; k < 4; k++) drive(1'b1, 1'b0);
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, 1'b0);
            checks++;
            if (dut_v() !== 8'h00) begin
                errors++;
                $display("FAIL rstmid_outputs cyc %0d: got %h want 00", k, dut_v());
            end
        end
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            drive(1'b1, 1'b0);
            checks++;
            if (rise_pulse !== (k == 6)) begin
                errors++;
                $display("FAIL rstmid_rise edge %0d: got %b want %b", k, rise_pulse, (k == 6));
            end
        end
        checks++;
        if (event_count !== CW'(1)) begin
            errors++;
            $display("FAIL rstmid_count: got %0d want 1", event_count);
        end
    endtask

    task automatic test_clear_stuck();
        do_reset();
        for (int k = 0; k < 32; k++) drive(1'b1, 1'b0);
        checks++;
        if (blocked_stuck !== 1'b1) begin
            errors++;
            $display("FAIL clrstuck_set: got %b want 1", blocked_stuck);
        end
        drive(1'b1, 1'b1);
        checks++;
        if ({blocked_stuck, event_count} !== {1'b0, CW'(0)}) begin
            errors++;
            $display("FAIL clrstuck_clear: got stuck %b count %0d want 0 0", blocked_stuck, event_count);
        end
        for (int j = 1; j <= 22; j++) begin
            drive(1'b1, 1'b0);
            checks++;
            if (blocked_stuck !== (j >= 20)) begin
                errors++;
                $display("FAIL clrstuck_reassert +%0d: got %b want %b", j, blocked_stuck, (j >= 20));
            end
        end
    endtask

    task automatic test_random();
        logic lvl = 1'b0;
        int   len;
        do_reset();
        for (int seg = 0; seg < 150; seg++) begin
            lvl = ~lvl;
            len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(10, 40)) : int'($urandom_range(1, 6));
            for (int k = 0; k < len; k++) begin
                if ($urandom_range(0, 299) == 0) rst = 1'b1;
                drive(lvl, $urandom_range(0, 49) == 0);
                rst = 1'b0;
                checks++;
                if (dut_v() !== model_v()) begin
                    errors++;
                    $display("FAIL random seg %0d cyc %0d: dut %h model %h", seg, k, dut_v(), model_v());
                end
                checks++;
                if (rise_pulse && fall_pulse) begin
                    errors++;
                    $display("FAIL random_both_pulses seg %0d: got 11 want not both", seg);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        sensor_raw = 1'b0;
        clear = 1'b0;
        @(negedge clk);
        test_reset();
        test_clean_step();
        test_glitch();
        test_chatter();
        test_saturation();
        test_reset_mid();
        test_clear_stuck();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
